// File: rtl/vga_timing_pixrep.sv
// vga_timing_pixrep: raster timing generator for VGA/DVI output.
// Produces H/V sync at programmable polarity, blank/vblank/DE, raw beam
// position, integer pixel/line repetition (1..4) with source indices and
// fetch strobes, a start-of-frame pulse and a wrapping frame counter.
// Optional feature macro: VGA_TIMING_TEST_PICTURE_EN adds the test_picture
// input that replaces active video with a generated pattern.
module vga_timing_pixrep #(
  parameter int C_RES_X      = 640,
  parameter int C_HFP        = 16,
  parameter int C_HPULSE     = 96,
  parameter int C_HBP        = 48,
  parameter int C_RES_Y      = 480,
  parameter int C_VFP        = 10,
  parameter int C_VPULSE     = 2,
  parameter int C_VBP        = 33,
  parameter int C_BITS_X     = 10,
  parameter int C_BITS_Y     = 10,
  parameter bit C_HSYNC_POL  = 1'b0,
  parameter bit C_VSYNC_POL  = 1'b0,
  parameter int C_REP_X      = 1,
  parameter int C_REP_Y      = 1,
  parameter int C_FRAME_BITS = 8
) (
  input  logic                    clk_pixel,
  input  logic                    rst_n,
  input  logic                    clk_pixel_ena,
`ifdef VGA_TIMING_TEST_PICTURE_EN
  input  logic                    test_picture,
`endif
  input  logic [7:0]              r_i,
  input  logic [7:0]              g_i,
  input  logic [7:0]              b_i,
  output logic                    fetch_next,
  output logic                    fetch_line,
  output logic [C_BITS_X-1:0]     beam_x,
  output logic [C_BITS_Y-1:0]     beam_y,
  output logic [C_BITS_X-1:0]     src_x,
  output logic [C_BITS_Y-1:0]     src_y,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_blank,
  output logic                    vga_vblank,
  output logic                    vga_de,
  output logic                    sof,
  output logic [C_FRAME_BITS-1:0] frame_count
);

  localparam int H_TOTAL = C_RES_X + C_HFP + C_HPULSE + C_HBP;
  localparam int V_TOTAL = C_RES_Y + C_VFP + C_VPULSE + C_VBP;

  localparam logic [C_BITS_X-1:0] X_LAST   = C_BITS_X'(H_TOTAL - 1);
  localparam logic [C_BITS_X-1:0] X_ACT    = C_BITS_X'(C_RES_X);
  localparam logic [C_BITS_X-1:0] X_HS_BEG = C_BITS_X'(C_RES_X + C_HFP);
  localparam logic [C_BITS_X-1:0] X_HS_END = C_BITS_X'(C_RES_X + C_HFP + C_HPULSE);
  localparam logic [C_BITS_Y-1:0] Y_LAST   = C_BITS_Y'(V_TOTAL - 1);
  localparam logic [C_BITS_Y-1:0] Y_ACT    = C_BITS_Y'(C_RES_Y);
  localparam logic [C_BITS_Y-1:0] Y_VS_BEG = C_BITS_Y'(C_RES_Y + C_VFP);
  localparam logic [C_BITS_Y-1:0] Y_VS_END = C_BITS_Y'(C_RES_Y + C_VFP + C_VPULSE);
  localparam logic [1:0]          REP_X_LAST = 2'(C_REP_X - 1);
  localparam logic [1:0]          REP_Y_LAST = 2'(C_REP_Y - 1);

  // Repetition factors outside 1..4 cannot be represented by the 2-bit
  // repeat counters; stop elaboration rather than produce a broken raster.
  if (C_REP_X < 1 || C_REP_X > 4) begin : g_bad_rep_x
    $fatal(1, "vga_timing_pixrep: C_REP_X must be in 1..4");
  end
  if (C_REP_Y < 1 || C_REP_Y > 4) begin : g_bad_rep_y
    $fatal(1, "vga_timing_pixrep: C_REP_Y must be in 1..4");
  end

  logic [C_BITS_X-1:0]     beam_x_q, beam_x_d;
  logic [C_BITS_Y-1:0]     beam_y_q, beam_y_d;
  logic [1:0]              rep_x_q, rep_x_d;
  logic [1:0]              rep_y_q, rep_y_d;
  logic [C_BITS_X-1:0]     src_x_q, src_x_d;
  logic [C_BITS_Y-1:0]     src_y_q, src_y_d;
  logic [C_FRAME_BITS-1:0] frame_q, frame_d;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    blank_q, blank_d;
  logic                    vblank_q, vblank_d;
  logic                    de_q, de_d;
  logic [7:0]              r_q, r_d, g_q, g_d, b_q, b_d;
  logic                    fetch_next_q, fetch_next_d;
  logic                    fetch_line_q, fetch_line_d;
  logic                    sof_q, sof_d;

  logic       x_wrap, y_wrap, h_act, v_act, active;
  logic [7:0] pix_r, pix_g, pix_b;

  assign x_wrap = (beam_x_q == X_LAST);
  assign y_wrap = (beam_y_q == Y_LAST);
  assign h_act  = (beam_x_q < X_ACT);
  assign v_act  = (beam_y_q < Y_ACT);
  assign active = h_act && v_act;

  // Source indices are only meaningful inside the picture; outside they read 0.
  assign src_x = active ? src_x_q : '0;
  assign src_y = active ? src_y_q : '0;

  // Pixel source: input stream, or the generated pattern when requested.
`ifdef VGA_TIMING_TEST_PICTURE_EN
  always_comb begin
    pix_r = r_i;
    pix_g = g_i;
    pix_b = b_i;
    if (test_picture) begin
      pix_r = 8'(src_x);
      pix_g = 8'(src_y);
      pix_b = (8'(src_x) == 8'(src_y)) ? 8'hFF : 8'h00;
    end
  end
`else
  always_comb begin
    pix_r = r_i;
    pix_g = g_i;
    pix_b = b_i;
  end
`endif

  // Beam, repetition, source-index and frame counter next state.
  always_comb begin
    beam_x_d = beam_x_q + C_BITS_X'(1);
    beam_y_d = beam_y_q;
    rep_x_d  = rep_x_q;
    rep_y_d  = rep_y_q;
    src_x_d  = src_x_q;
    src_y_d  = src_y_q;
    frame_d  = frame_q;
    if (x_wrap) begin
      beam_x_d = '0;
      rep_x_d  = '0;
      src_x_d  = '0;
      if (y_wrap) begin
        beam_y_d = '0;
        rep_y_d  = '0;
        src_y_d  = '0;
        frame_d  = frame_q + C_FRAME_BITS'(1);
      end else begin
        beam_y_d = beam_y_q + C_BITS_Y'(1);
        if (v_act) begin
          if (rep_y_q == REP_Y_LAST) begin
            rep_y_d = '0;
            src_y_d = src_y_q + C_BITS_Y'(1);
          end else begin
            rep_y_d = rep_y_q + 2'd1;
          end
        end
      end
    end else if (h_act) begin
      if (rep_x_q == REP_X_LAST) begin
        rep_x_d = '0;
        src_x_d = src_x_q + C_BITS_X'(1);
      end else begin
        rep_x_d = rep_x_q + 2'd1;
      end
    end
  end

  // Position decode into the values registered at the next enabled edge.
  always_comb begin
    hsync_d  = ((beam_x_q >= X_HS_BEG) && (beam_x_q < X_HS_END)) ? C_HSYNC_POL : ~C_HSYNC_POL;
    vsync_d  = ((beam_y_q >= Y_VS_BEG) && (beam_y_q < Y_VS_END)) ? C_VSYNC_POL : ~C_VSYNC_POL;
    blank_d  = ~active;
    vblank_d = ~v_act;
    de_d     = active;
    r_d      = active ? pix_r : 8'h00;
    g_d      = active ? pix_g : 8'h00;
    b_d      = active ? pix_b : 8'h00;
    // Only the last repeated line pulls new data; earlier repeats replay.
    fetch_next_d = clk_pixel_ena && active && (rep_x_q == REP_X_LAST) && (rep_y_q == REP_Y_LAST);
    fetch_line_d = clk_pixel_ena && (beam_x_q == '0) && v_act && (rep_y_q == '0);
    sof_d        = clk_pixel_ena && (beam_x_q == '0) && (beam_y_q == '0);
  end

  // State and output registers; pulses clear on disabled cycles, all else holds.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      beam_x_q     <= '0;
      beam_y_q     <= '0;
      rep_x_q      <= '0;
      rep_y_q      <= '0;
      src_x_q      <= '0;
      src_y_q      <= '0;
      frame_q      <= '0;
      hsync_q      <= ~C_HSYNC_POL;
      vsync_q      <= ~C_VSYNC_POL;
      blank_q      <= 1'b1;
      vblank_q     <= 1'b1;
      de_q         <= 1'b0;
      r_q          <= 8'h00;
      g_q          <= 8'h00;
      b_q          <= 8'h00;
      fetch_next_q <= 1'b0;
      fetch_line_q <= 1'b0;
      sof_q        <= 1'b0;
    end else begin
      fetch_next_q <= fetch_next_d;
      fetch_line_q <= fetch_line_d;
      sof_q        <= sof_d;
      if (clk_pixel_ena) begin
        beam_x_q <= beam_x_d;
        beam_y_q <= beam_y_d;
        rep_x_q  <= rep_x_d;
        rep_y_q  <= rep_y_d;
        src_x_q  <= src_x_d;
        src_y_q  <= src_y_d;
        frame_q  <= frame_d;
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        blank_q  <= blank_d;
        vblank_q <= vblank_d;
        de_q     <= de_d;
        r_q      <= r_d;
        g_q      <= g_d;
        b_q      <= b_d;
      end
    end
  end

  assign beam_x      = beam_x_q;
  assign beam_y      = beam_y_q;
  assign frame_count = frame_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_blank   = blank_q;
  assign vga_vblank  = vblank_q;
  assign vga_de      = de_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign fetch_next  = fetch_next_q;
  assign fetch_line  = fetch_line_q;
  assign sof         = sof_q;

endmodule

// File: tb/tb_vga_timing_pixrep.sv
// Bench for vga_timing_pixrep: two instances on a 16x8 raster.
// dut_a: no repetition, negative syncs, 2-bit frame counter.
// dut_b: 2x2 repetition, positive syncs, 8-bit frame counter.
module tb_vga_timing_pixrep;

  localparam int RX = 8, HFP = 2, HP = 3, HBP = 3;
  localparam int RY = 4, VFP = 1, VP = 1, VBP = 2;
  localparam int HT = 16, VT = 8;

  typedef struct packed {
    logic hs, vs, blank, vblank, de, fn, fl, sof;
    logic [7:0] r, g, b;
  } out_t;

  logic clk, rst_n, ena, tp;
  logic [7:0] r_i, g_i, b_i;

  logic a_fn, a_fl, a_hs, a_vs, a_bl, a_vbl, a_de, a_sof;
  logic [9:0] a_bx, a_by, a_sx, a_sy;
  logic [7:0] a_r, a_g, a_b;
  logic [1:0] a_fc;
  logic b_fn, b_fl, b_hs, b_vs, b_bl, b_vbl, b_de, b_sof;
  logic [9:0] b_bx, b_by, b_sx, b_sy;
  logic [7:0] b_r, b_g, b_b;
  logic [7:0] b_fc;

  int total = 0;
  int bad = 0;

  vga_timing_pixrep #(
    .C_RES_X(RX), .C_HFP(HFP), .C_HPULSE(HP), .C_HBP(HBP),
    .C_RES_Y(RY), .C_VFP(VFP), .C_VPULSE(VP), .C_VBP(VBP),
    .C_BITS_X(10), .C_BITS_Y(10), .C_HSYNC_POL(1'b0), .C_VSYNC_POL(1'b0),
    .C_REP_X(1), .C_REP_Y(1), .C_FRAME_BITS(2)
  ) dut_a (
    .clk_pixel(clk), .rst_n(rst_n), .clk_pixel_ena(ena),
`ifdef VGA_TIMING_TEST_PICTURE_EN
    .test_picture(tp),
`endif
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .fetch_next(a_fn), .fetch_line(a_fl), .beam_x(a_bx), .beam_y(a_by),
    .src_x(a_sx), .src_y(a_sy), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_blank(a_bl), .vga_vblank(a_vbl),
    .vga_de(a_de), .sof(a_sof), .frame_count(a_fc)
  );

  vga_timing_pixrep #(
    .C_RES_X(RX), .C_HFP(HFP), .C_HPULSE(HP), .C_HBP(HBP),
    .C_RES_Y(RY), .C_VFP(VFP), .C_VPULSE(VP), .C_VBP(VBP),
    .C_BITS_X(10), .C_BITS_Y(10), .C_HSYNC_POL(1'b1), .C_VSYNC_POL(1'b1),
    .C_REP_X(2), .C_REP_Y(2), .C_FRAME_BITS(8)
  ) dut_b (
    .clk_pixel(clk), .rst_n(rst_n), .clk_pixel_ena(ena),
`ifdef VGA_TIMING_TEST_PICTURE_EN
    .test_picture(tp),
`endif
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .fetch_next(b_fn), .fetch_line(b_fl), .beam_x(b_bx), .beam_y(b_by),
    .src_x(b_sx), .src_y(b_sy), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_blank(b_bl), .vga_vblank(b_vbl),
    .vga_de(b_de), .sof(b_sof), .frame_count(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rep_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int fmod_of(int k);
    return (k == 0) ? 4 : 256;
  endfunction

  function automatic out_t reset_out(int k);
    out_t o;
    logic pol;
    pol = (k == 1);
    o = '0;
    o.hs = !pol;
    o.vs = !pol;
    o.blank = 1'b1;
    o.vblank = 1'b1;
    return o;
  endfunction

  // What the registered outputs must show after an enabled edge at (x,y).
  function automatic out_t predict(int k, int x, int y, logic [7:0] ri, logic [7:0] gi,
                                   logic [7:0] bi, logic t);
    out_t o;
    int rp;
    logic pol;
    bit act;
    rp = rep_of(k);
    pol = (k == 1);
    act = (x < RX) && (y < RY);
    o = '0;
    o.hs = (x >= RX + HFP && x < RX + HFP + HP) ? pol : !pol;
    o.vs = (y >= RY + VFP && y < RY + VFP + VP) ? pol : !pol;
    o.blank = !act;
    o.vblank = (y >= RY);
    o.de = act;
    if (act) begin
      if (t) begin
        o.r = 8'(x / rp);
        o.g = 8'(y / rp);
        o.b = ((x / rp) == (y / rp)) ? 8'hFF : 8'h00;
      end else begin
        o.r = ri;
        o.g = gi;
        o.b = bi;
      end
    end
    o.fn = act && (x % rp == rp - 1) && (y % rp == rp - 1);
    o.fl = (x == 0) && (y < RY) && (y % rp == 0);
    o.sof = (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic logic [47:0] ppos(int k, int x, int y, int fc);
    int sx, sy;
    bit act;
    act = (x < RX) && (y < RY);
    sx = act ? x / rep_of(k) : 0;
    sy = act ? y / rep_of(k) : 0;
    return {10'(x), 10'(y), 10'(sx), 10'(sy), 8'(fc)};
  endfunction

  int mx[2], my[2], mfc[2];
  out_t e[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mx[k] <= 0;
        my[k] <= 0;
        mfc[k] <= 0;
        e[k] <= reset_out(k);
      end
    end else if (ena) begin
      for (int k = 0; k < 2; k++) begin
        e[k] <= predict(k, mx[k], my[k], r_i, g_i, b_i, tp);
        mx[k] <= (mx[k] + 1) % HT;
        if (mx[k] == HT - 1) my[k] <= (my[k] + 1) % VT;
        if (mx[k] == HT - 1 && my[k] == VT - 1) mfc[k] <= (mfc[k] + 1) % fmod_of(k);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        e[k].fn <= 1'b0;
        e[k].fl <= 1'b0;
        e[k].sof <= 1'b0;
      end
    end
  end

  out_t d_o[2];
  logic [47:0] d_p[2];
  assign d_o[0] = {a_hs, a_vs, a_bl, a_vbl, a_de, a_fn, a_fl, a_sof, a_r, a_g, a_b};
  assign d_o[1] = {b_hs, b_vs, b_bl, b_vbl, b_de, b_fn, b_fl, b_sof, b_r, b_g, b_b};
  assign d_p[0] = {a_bx, a_by, a_sx, a_sy, 6'b0, a_fc};
  assign d_p[1] = {b_bx, b_by, b_sx, b_sy, b_fc};

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("outputs_dut%0d", k), 64'(d_o[k]), 64'(e[k]));
      chk($sformatf("position_dut%0d", k), 64'(d_p[k]), 64'(ppos(k, mx[k], my[k], mfc[k])));
    end
  end

  // ---------------- directed stimulus ----------------
  int de_a, hsl_a, fn_ok, fn_bad, fl_b, sof1, r_on, r_leak, hs_fall_x, nsof;
  int last_sof, period1, period2, chg, sof_wide, fn_wide, found, tp_hits;
  int fc_seq[5];
  int fc_exp[5] = '{0, 1, 2, 3, 0};
  int sxs[8];
  int sx_exp[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  logic prev_hs, prev_sof, prev_fn;
  logic [9:0] prev_bx;

  initial begin
    rst_n = 1'b0; ena = 1'b1; tp = 1'b0;
    r_i = 8'hA5; g_i = 8'h00; b_i = 8'h00;
    de_a = 0; hsl_a = 0; fn_ok = 0; fn_bad = 0; fl_b = 0; sof1 = 0;
    r_on = 0; r_leak = 0; hs_fall_x = -1; nsof = 0; last_sof = -1; period1 = -1;
    for (int i = 0; i < 8; i++) sxs[i] = -1;
    for (int i = 0; i < 5; i++) fc_seq[i] = -1;
    prev_hs = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_beam_x_a", 64'(a_bx), 0);
    chk("rst_beam_y_b", 64'(b_by), 0);
    chk("rst_blank_a", 64'(a_bl), 1);
    chk("rst_vblank_a", 64'(a_vbl), 1);
    chk("rst_de_a", 64'(a_de), 0);
    chk("rst_hsync_a_idle_high", 64'(a_hs), 1);
    chk("rst_hsync_b_idle_low", 64'(b_hs), 0);
    chk("rst_vsync_b_idle_low", 64'(b_vs), 0);
    chk("rst_r_a", 64'(a_r), 0);
    chk("rst_sof_a", 64'(a_sof), 0);
    chk("rst_fc_b", 64'(b_fc), 0);
    rst_n = 1'b1;

    // Five frames with enable tied high.
    for (int i = 0; i < 640; i++) begin
      @(posedge clk);
      #1;
      g_i = 8'(i);
      b_i = 8'(i * 3);
      if (i == 0) chk("sof_one_clock_after_release", 64'(b_sof), 1);
      if (i < 128) begin
        de_a += int'(a_de);
        hsl_a += int'(!a_hs);
        if (b_fn) begin
          if (b_by == 1 || b_by == 3) fn_ok++;
          else fn_bad++;
        end
        fl_b += int'(b_fl);
        sof1 += int'(a_sof);
        if (a_r == 8'hA5 && a_de) r_on++;
        if (!a_de && a_r != 8'h00) r_leak++;
        if (prev_hs && !a_hs && hs_fall_x < 0) hs_fall_x = int'(a_bx);
        prev_hs = a_hs;
        if (b_by == 0 && b_bx < 8) sxs[b_bx[2:0]] = int'(b_sx);
      end
      if (a_sof) begin
        if (nsof < 5) fc_seq[nsof] = int'(a_fc);
        nsof++;
        if (last_sof >= 0 && period1 < 0) period1 = i - last_sof;
        last_sof = i;
      end
    end
    chk("de_clocks_per_frame", 64'(de_a), 32);
    chk("hsync_low_clocks_per_frame", 64'(hsl_a), 24);
    chk("hsync_first_low_at_beam_x", 64'(hs_fall_x), 11);
    chk("fetch_next_on_lines_1_3", 64'(fn_ok), 8);
    chk("fetch_next_on_other_lines", 64'(fn_bad), 0);
    chk("fetch_line_per_frame", 64'(fl_b), 2);
    chk("sof_per_frame", 64'(sof1), 1);
    chk("rgb_a5_while_de", 64'(r_on), 32);
    chk("rgb_nonzero_outside_de", 64'(r_leak), 0);
    chk("sof_period_ena_high", 64'(period1), 128);
    chk("sof_count_5_frames", 64'(nsof), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("frame_count_at_sof%0d", i), 64'(fc_seq[i]), 64'(fc_exp[i]));
    for (int i = 0; i < 8; i++) chk($sformatf("src_x_seq%0d", i), 64'(sxs[i]), 64'(sx_exp[i]));

    // Enable toggling 1,0,1,0: half-rate counters, one-clock pulses.
    last_sof = -1; period2 = -1; chg = 0; sof_wide = 0; fn_wide = 0;
    prev_sof = 1'b0; prev_fn = 1'b0; prev_bx = a_bx;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (a_bx != prev_bx) chg++;
      prev_bx = a_bx;
      if (a_sof && prev_sof) sof_wide++;
      if (b_fn && prev_fn) fn_wide++;
      prev_sof = a_sof;
      prev_fn = b_fn;
      if (a_sof) begin
        if (last_sof >= 0 && period2 < 0) period2 = i - last_sof;
        last_sof = i;
      end
      ena = ~ena;
    end
    ena = 1'b1;
    chk("beam_changes_half_rate", 64'(chg), 300);
    chk("sof_wider_than_one_clock", 64'(sof_wide), 0);
    chk("fetch_next_wider_than_one_clock", 64'(fn_wide), 0);
    chk("sof_period_ena_toggling", 64'(period2), 256);

    // Mid-frame reset while dut_b hsync is asserted (high).
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (b_hs) found = 1;
    end
    chk("wait_hsync_b_high", 64'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hsync_b_low_now", 64'(b_hs), 0);
    chk("mid_rst_vsync_b_low_now", 64'(b_vs), 0);
    chk("mid_rst_hsync_a_high_now", 64'(a_hs), 1);
    chk("mid_rst_beam_x_zero", 64'(b_bx), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("sof_one_clock_after_mid_release", 64'(b_sof), 1);
    chk("beam_x_after_mid_release", 64'(a_bx), 1);

`ifdef VGA_TIMING_TEST_PICTURE_EN
    tp = 1'b1;
    tp_hits = 0;
    for (int i = 0; i < 300 && tp_hits < 2; i++) begin
      @(posedge clk);
      #1;
      if (a_by == 3 && a_bx == 4) begin
        chk("tp_r_at_3_3", 64'(a_r), 3);
        chk("tp_g_at_3_3", 64'(a_g), 3);
        chk("tp_b_at_3_3", 64'(a_b), 64'hFF);
        tp_hits++;
      end
      if (a_by == 2 && a_bx == 4) begin
        chk("tp_g_at_3_2", 64'(a_g), 2);
        chk("tp_b_at_3_2", 64'(a_b), 0);
        tp_hits++;
      end
    end
    chk("tp_positions_seen", 64'(tp_hits), 2);
    tp = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_pixrep.md
Name: vga_timing_pixrep

Overview:
- Parametrised successor to the team's VGA/DVI raster generator.
- Generates H/V sync, blank, DE and beam position from generic timing parameters.
- Adds the following features:
  - programmable sync polarity;
  - integer pixel/line repetition (1..4) for upscaling a smaller source bitmap;
  - a per-source-line fetch request;
  - start-of-frame pulse and frame counter.
- Sits between a pixel-clock-synchronous FIFO/line buffer and the HDMI/VGA output encoders.

Parameters:
- C_RES_X, 640, active pixels per line
- C_HFP, 16, H front porch (pixels)
- C_HPULSE, 96, H sync pulse width
- C_HBP, 48, H back porch
- C_RES_Y, 480, active lines
- C_VFP, 10, V front porch (lines)
- C_VPULSE, 2, V sync width
- C_VBP, 33, V back porch
- C_BITS_X, 10, beam_x width; must hold H_TOTAL-1
- C_BITS_Y, 10, beam_y width; must hold V_TOTAL-1
- C_HSYNC_POL, 0, active level of vga_hsync (0 = negative pulse)
- C_VSYNC_POL, 0, active level of vga_vsync
- C_REP_X, 1, output pixels per source pixel, 1..4
- C_REP_Y, 1, output lines per source line, 1..4
- C_FRAME_BITS, 8, frame_count width

Ports:
- clk_pixel  in  1  pixel clock
- rst_n  in  1  async active-low reset
- clk_pixel_ena  in  1  pixel clock enable; all state advances only when high
- r_i, g_i, b_i  in  8 each  source pixel, valid before fetch_next consumes it
- fetch_next  out  1  one-clk pulse: current source pixel consumed
- fetch_line  out  1  one-clk pulse: new source line begins, FIFO may rewind/advance line
- beam_x  out  C_BITS_X  raw horizontal counter
- beam_y  out  C_BITS_Y  raw vertical counter
- src_x  out  C_BITS_X  source pixel index (beam_x / C_REP_X, active area)
- src_y  out  C_BITS_Y  source line index (beam_y / C_REP_Y, active area)
- vga_r, vga_g, vga_b  out  8 each  registered video
- vga_hsync, vga_vsync  out  1  sync at programmed polarity
- vga_blank, vga_vblank, vga_de  out  1  blank (H or V), V blank, display enable = ~blank
- sof  out  1  one-clk pulse at start of frame
- frame_count  out  C_FRAME_BITS  frames completed, wraps

Behaviour:
- Frame geometry:
  - H_TOTAL = C_RES_X + C_HFP + C_HPULSE + C_HBP.
  - V_TOTAL likewise from the vertical parameters.
- Counter stepping, on each enabled cycle:
  - beam_x increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, beam_y increments and wraps V_TOTAL-1 -> 0.
- Position decode:
  - active = (beam_x < C_RES_X) && (beam_y < C_RES_Y).
  - hsync active for beam_x in [C_RES_X+C_HFP, C_RES_X+C_HFP+C_HPULSE).
  - vsync active likewise for beam_y.
- Output registration and latency:
  - vga_hsync/vsync/blank/vblank/de/rgb are registered from the current counter position.
  - They update only on enabled cycles, so each output lags beam_x/beam_y by exactly one enabled cycle.
  - Sync output = C_xSYNC_POL when active, else its inverse.
- Repetition counters:
  - rep_x counts 0..C_REP_X-1 within the active area and is cleared at beam_x = 0.
  - rep_y counts 0..C_REP_Y-1, advances on each line wrap, and is cleared at beam_y = 0.
  - src_x/src_y advance when rep_x/rep_y wrap.
  - src_x/src_y read 0 outside the active area.
- fetch_next:
  - High for exactly one clk_pixel cycle following an enabled cycle where active && rep_x == C_REP_X-1 && rep_y == C_REP_Y-1.
  - Only the last repeated line consumes FIFO data; earlier repeats replay from the line buffer.
  - Low in all other cycles, including non-enabled ones.
- fetch_line: one-clk pulse after an enabled cycle with beam_x == 0, beam_y < C_RES_Y and rep_y == 0.
- sof: one-clk pulse after the enabled cycle at beam_x = 0, beam_y = 0.
- frame_count: increments on the V wrap (beam_x = H_TOTAL-1, beam_y = V_TOTAL-1); wraps at 2^C_FRAME_BITS.
- Video: vga_rgb = r/g/b_i when active, else 0.
- Reset (async assert, sync release on clk_pixel):
  - Counters, rep counters, src_x/src_y and frame_count are 0.
  - RGB is 0; de/fetch_next/fetch_line/sof are 0.
  - blank and vblank are 1.
  - hsync/vsync are at the inactive level.
  - Reset mid-line abandons the frame; the first frame after release begins at (0,0) and its sof pulse is emitted.
- clk_pixel_ena low holds all state and outputs; the pulse outputs go low.
- C_REP_X/C_REP_Y outside 1..4 are illegal; a simulation-only check reports a fatal error.

Optional Feature:
- Macro VGA_TIMING_TEST_PICTURE_EN.
- When defined: adds input test_picture.
  - When test_picture is high, active video is replaced by a generated pattern.
  - r = src_x[7:0], g = src_y[7:0], b = 8'hFF when src_x[7:0] == src_y[7:0], else 8'h00.
  - fetch_next is still generated.
- When undefined: no test_picture port; video always from r_i/g_i/b_i.

Test Plan:
1. Timing at C_RES_X=8, C_HFP=2, C_HPULSE=3, C_HBP=3, C_RES_Y=4, C_VFP=1, C_VPULSE=1, C_VBP=2, ena tied 1:
   - H_TOTAL=16 and V_TOTAL=8.
   - vga_hsync is low for beam_x 10..12, seen one clock later.
   - vga_de is high 8 clocks per line, 4 lines per frame.
   - sof every 128 clocks.
2. Same geometry, C_REP_X=2, C_REP_Y=2:
   - fetch_next gives 4 pulses per line, only on lines 1 and 3.
   - fetch_line pulses on lines 0 and 2.
   - src_x sequence 0,0,1,1,2,2,3,3.
3. clk_pixel_ena toggled 1,0,1,0:
   - Counters advance every other clock.
   - fetch_next/sof pulses are one clock wide.
   - Frame period is 256 clocks.
4. C_HSYNC_POL=1, C_VSYNC_POL=1: syncs are idle low, pulse high. Assert rst_n mid-frame: syncs go low immediately, and the first sof occurs 1 clock after release.
5. C_FRAME_BITS=2:
   - frame_count steps 0,1,2,3,0 across 5 frames.
   - RGB inputs 8'hA5 appear on vga_r only while vga_de=1; otherwise 0.
6. With VGA_TIMING_TEST_PICTURE_EN defined and test_picture=1: the pixel at src (3,3) outputs r=3, g=3, b=8'hFF; at (3,2) b=0.
